registro_fifo_uart: RTL and testbench
=====================================

# registro_fifo_uart

Parametrised UART register block between the CPU bus and the UART TX/RX engines. It replaces the single-entry data/control register pair with a TX FIFO and an RX FIFO of configurable width and depth. It also provides a status register with sticky error flags and an optional interrupt. CPU accesses are single-cycle write and registered read; the UART side uses valid/ready streaming.

## Interface
- DATA_W, 8: UART character width, 5..9.
- DEPTH, 8: entries per FIFO, power of two, ≥2.
- clk_i  in  1  single system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- addr_i  in  2  CPU register select: 0 STATUS, 1 TXDATA, 2 RXDATA, 3 IRQEN.
- we_i  in  1  CPU write strobe, one cycle per access.
- re_i  in  1  CPU read strobe, one cycle per access.
- wdata_i  in  32  CPU write data.
- rdata_o  out  32  CPU read data, registered.
- tx_data_o  out  DATA_W  TX FIFO head (first-word fall-through).
- tx_valid_o  out  1  TX FIFO not empty.
- tx_ready_i  in  1  UART TX accepts head this cycle.
- rx_data_i  in  DATA_W  received character.
- rx_valid_i  in  1  push strobe from the UART RX engine (one cycle per character).
- irq_o  out  1  interrupt; exists only with UART_IRQ_EN.

## Operation
- Writes:
  - TXDATA write pushes wdata_i[DATA_W-1:0] if TX count < DEPTH. Otherwise the data is dropped and TX_OVF is set.
  - STATUS write with bit n=1 clears sticky bit n (W1C). It applies only to bits 4 and 5.
  - IRQEN write loads bits[3:0].
  - Writes to RXDATA are ignored.
- Reads:
  - RXDATA read pops the RX head when not empty and returns it zero-extended. Reading an empty RX FIFO returns 0 and does not move the pointers.
  - STATUS read returns: [0] TX_EMPTY, [1] TX_FULL, [2] RX_EMPTY, [3] RX_FULL, [4] TX_OVF, [5] RX_OVR, [11:8] TX count, [19:16] RX count (count fields truncated to 4 bits), other bits 0.
  - IRQEN read returns the enable bits in [3:0].
  - TXDATA read returns 0.
- RX push: rx_valid_i pushes rx_data_i if RX count < DEPTH. Otherwise the character is dropped and RX_OVR is set.
- TX pop: occurs when tx_valid_o && tx_ready_i.
- we_i && re_i in the same cycle: the write takes effect and the read is ignored (rdata_o holds its value).
- Full/empty checks use the count at the start of the cycle.
  - A push to a full FIFO is dropped, even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits.

## Timing
- Reset values:
  - rdata_o=0, tx_valid_o=0, tx_data_o=0, irq_o=0.
  - Both FIFOs empty, sticky flags 0, IRQEN=0.
- Reset asserted mid-operation flushes both FIFOs on the next edge. In-flight data is discarded.
- Register read latency: 1. rdata_o is updated on the edge where re_i is sampled high and holds until the next accepted read.
- STATUS reflects state before the edge of the read, not including any same-cycle push or pop.
- TXDATA write to an empty FIFO: tx_valid_o=1 the cycle after the write edge.
- RX push: count increments after the edge, so a read issued the following cycle sees the new data.
- Sticky flags set on the edge of the dropped push. If a W1C and a new overflow coincide, set wins.

## Configuration
- UART_IRQ_EN defined:
  - irq_o is registered: OR of (IRQEN[0] & TX_EMPTY), (IRQEN[1] & !RX_EMPTY), (IRQEN[2] & TX_OVF), (IRQEN[3] & RX_OVR).
  - It updates one cycle after the underlying condition changes.
- UART_IRQ_EN undefined:
  - irq_o port is absent and no irq logic exists.
  - IRQEN still stores its bits and is readable.

## Structure
- Package uart_regs_pkg holds:
  - address constants ADDR_STATUS/ADDR_TXDATA/ADDR_RXDATA/ADDR_IRQEN;
  - STATUS bit-index localparams;
  - a status_t packed struct.
- One sub-module, fifo_sync #(DATA_W, DEPTH), instantiated twice. It has push/pop/data ports, first-word fall-through head output, empty/full/count outputs, and drop-on-full behaviour.
- Top level contains the address decode, sticky flags, the read mux register and the irq logic.

## Test plan
Benches run with DATA_W=8, DEPTH=4.
- Reset at mid-traffic with 3 TX entries queued → next cycle tx_valid_o=0, STATUS read = 0x0000_0005.
- Write TXDATA 0x41, 0x42 with tx_ready_i=0 → tx_valid_o=1, tx_data_o=0x41, STATUS[11:8]=2. Raise tx_ready_i for 2 cycles → 0x41 then 0x42 popped, tx_valid_o=0.
- Write TXDATA five times (0x01..0x05) with no pops → STATUS=0x0000_0416 (TX_FULL, RX_EMPTY, TX_OVF, TX count 4). Write STATUS 0x10 → TX_OVF clears.
- Pulse rx_valid_i with 0x55, 0xAA → STATUS[19:16]=2. RXDATA reads return 0x55 then 0xAA. A third read returns 0 with count unchanged.
- Push 5 RX characters → RX_OVR=1. Same-cycle W1C and a new overflow → RX_OVR stays 1.
- UART_IRQ_EN: IRQEN=0x2, push one RX character → irq_o=1 one cycle later. Read RXDATA → irq_o=0 two cycles after the read strobe.

Source files
------------

// File: rtl/uart_regs_pkg.sv
// Shared register map for registro_fifo_uart: addresses, STATUS bit positions and layout.
package uart_regs_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_TXDATA = 2'd1;
  localparam logic [1:0] ADDR_RXDATA = 2'd2;
  localparam logic [1:0] ADDR_IRQEN  = 2'd3;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVR   = 5;

  typedef struct packed {
    logic [11:0] rsv_hi;
    logic [3:0]  rx_count;
    logic [3:0]  rsv_mid;
    logic [3:0]  tx_count;
    logic [1:0]  rsv_lo;
    logic        rx_ovr;
    logic        tx_ovf;
    logic        rx_full;
    logic        rx_empty;
    logic        tx_full;
    logic        tx_empty;
  } status_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with first-word fall-through head; pushes to a full FIFO are dropped.
module fifo_sync #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  // Full/empty are judged on the count at the start of the cycle.
  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? DATA_W'(0) : mem[rptr];

  // Storage array
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/registro_fifo_uart.sv
// UART register block: TX/RX FIFOs, STATUS with sticky W1C errors, IRQEN.
// Optional interrupt output enabled by defining UART_IRQ_EN.
module registro_fifo_uart
  import uart_regs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i
`ifdef UART_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              tx_push, tx_pop, tx_empty, tx_full;
  logic              rx_pop, rx_empty, rx_full;
  logic [CW-1:0]     tx_count, rx_count;
  logic [DATA_W-1:0] rx_head;
  logic              rd;
  logic              tx_ovf, rx_ovr;
  logic [3:0]        irqen;
  status_t           status;
  logic [31:0]       rmux;

  // A write in the same cycle as a read wins; the read is dropped.
  assign rd         = re_i && !we_i;
  assign tx_push    = we_i && (addr_i == ADDR_TXDATA);
  assign tx_pop     = !tx_empty && tx_ready_i;
  assign rx_pop     = rd && (addr_i == ADDR_RXDATA);
  assign tx_valid_o = !tx_empty;

  fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(tx_push), .pop(tx_pop),
    .wdata(wdata_i[DATA_W-1:0]), .rdata(tx_data_o),
    .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(rx_valid_i), .pop(rx_pop),
    .wdata(rx_data_i), .rdata(rx_head),
    .empty(rx_empty), .full(rx_full), .count(rx_count)
  );

  // STATUS view of the pre-edge state
  always_comb begin
    status          = '0;
    status.tx_empty = tx_empty;
    status.tx_full  = tx_full;
    status.rx_empty = rx_empty;
    status.rx_full  = rx_full;
    status.tx_ovf   = tx_ovf;
    status.rx_ovr   = rx_ovr;
    status.tx_count = 4'(tx_count);
    status.rx_count = 4'(rx_count);
  end

  // Sticky error flags (a new overflow beats a same-cycle clear) and IRQEN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_ovf <= 1'b0;
      rx_ovr <= 1'b0;
      irqen  <= 4'd0;
    end else begin
      tx_ovf <= (tx_push && tx_full) ||
                (tx_ovf && !(we_i && addr_i == ADDR_STATUS && wdata_i[ST_TX_OVF]));
      rx_ovr <= (rx_valid_i && rx_full) ||
                (rx_ovr && !(we_i && addr_i == ADDR_STATUS && wdata_i[ST_RX_OVR]));
      if (we_i && addr_i == ADDR_IRQEN) begin
        irqen <= wdata_i[3:0];
      end
    end
  end

  // Read data multiplexer
  always_comb begin
    rmux = 32'd0;
    case (addr_i)
      ADDR_STATUS: rmux = status;
      ADDR_TXDATA: rmux = 32'd0;
      ADDR_RXDATA: rmux = 32'(rx_head);
      ADDR_IRQEN:  rmux = {28'd0, irqen};
      default:     rmux = 32'd0;
    endcase
  end

  // Registered read data, held until the next accepted read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= 32'd0;
    end else if (rd) begin
      rdata_o <= rmux;
    end
  end

`ifdef UART_IRQ_EN
  // Registered interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= (irqen[0] && tx_empty) || (irqen[1] && !rx_empty) ||
               (irqen[2] && tx_ovf)   || (irqen[3] && rx_ovr);
    end
  end
`endif

endmodule

// File: tb/tb_registro_fifo_uart.sv
// Self-checking bench for registro_fifo_uart (DATA_W=8, DEPTH=4); scoreboard queues for TX and RX data.
module tb_registro_fifo_uart;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        addr_i = 2'd0;
  logic              we_i = 1'b0;
  logic              re_i = 1'b0;
  logic [31:0]       wdata_i = 32'd0;
  logic [31:0]       rdata_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i = 1'b0;
  logic [DATA_W-1:0] rx_data_i = 8'd0;
  logic              rx_valid_i = 1'b0;
`ifdef UART_IRQ_EN
  logic              irq_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  registro_fifo_uart #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .we_i(we_i), .re_i(re_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i)
`ifdef UART_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  // Inputs change on the falling edge; outputs are observed on the falling edge.
  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a; wdata_i = d; we_i = 1'b1;
    if (a == 2'd1 && txq.size() < DEPTH) txq.push_back(d[7:0]);
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_i = a; re_i = 1'b1;
    @(negedge clk);
    re_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic rx_push(input logic [7:0] c);
    @(negedge clk);
    rx_data_i = c; rx_valid_i = 1'b1;
    if (rxq.size() < DEPTH) rxq.push_back(c);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic drain_tx(input string name);
    int budget;
    logic [7:0] exp;
    budget = 0;
    @(negedge clk);
    tx_ready_i = 1'b1;
    while (txq.size() > 0 && budget < 20) begin
      exp = txq.pop_front();
      total++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== exp) begin
        bad++;
        $display("FAIL %s: valid=%0b data=%h expected valid=1 data=%h", name, tx_valid_o, tx_data_o, exp);
      end
      @(negedge clk);
      budget++;
    end
    tx_ready_i = 1'b0;
    total++;
    if (tx_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_empty: tx_valid=%0b expected 0", name, tx_valid_o);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 || rdata_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%0b data=%h rdata=%h expected 0 0 0", tx_valid_o, tx_data_o, rdata_o);
    end
    rst_i = 1'b0;
    cpu_read(2'd0, d);
    total++;
    if (d !== 32'h5) begin bad++; $display("FAIL reset_status: got %h expected 00000005", d); end
    cpu_read(2'd3, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_irqen: got %h expected 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    cpu_write(2'd1, 32'h11);
    cpu_write(2'd1, 32'h22);
    cpu_write(2'd1, 32'h33);
    total++;
    if (tx_valid_o !== 1'b1) begin bad++; $display("FAIL mid_pre: tx_valid=%0b expected 1", tx_valid_o); end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    txq.delete();
    total++;
    if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL mid_flush: tx_valid=%0b expected 0", tx_valid_o); end
    cpu_read(2'd0, d);
    total++;
    if (d !== 32'h5) begin bad++; $display("FAIL mid_status: got %h expected 00000005", d); end
  endtask

  task automatic test_tx_stream();
    logic [31:0] d;
    cpu_write(2'd1, 32'h41);
    cpu_write(2'd1, 32'h42);
    total++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41) begin
      bad++; $display("FAIL tx_head: valid=%0b data=%h expected 1 41", tx_valid_o, tx_data_o);
    end
    cpu_read(2'd0, d);
    total++;
    if (d[11:8] !== 4'd2) begin bad++; $display("FAIL tx_count: got %0d expected 2", d[11:8]); end
    cpu_read(2'd1, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL txdata_read: got %h expected 0", d); end
    drain_tx("tx_stream");
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    for (int i = 1; i <= 5; i++) cpu_write(2'd1, 32'(i));
    cpu_read(2'd0, d);
    total++;
    if (d !== 32'h416) begin bad++; $display("FAIL tx_ovf_status: got %h expected 00000416", d); end
    cpu_write(2'd0, 32'h10);
    cpu_read(2'd0, d);
    total++;
    if (d !== 32'h406) begin bad++; $display("FAIL tx_ovf_clear: got %h expected 00000406", d); end
    // Full FIFO with a same-cycle pop: the push is still dropped.
    @(negedge clk);
    addr_i = 2'd1; wdata_i = 32'h99; we_i = 1'b1; tx_ready_i = 1'b1;
    void'(txq.pop_front());
    @(negedge clk);
    we_i = 1'b0; tx_ready_i = 1'b0;
    cpu_read(2'd0, d);
    total++;
    if (d !== 32'h314) begin bad++; $display("FAIL full_push_pop: got %h expected 00000314", d); end
    // Non-full, non-empty push with pop: count stays at 3.
    @(negedge clk);
    addr_i = 2'd1; wdata_i = 32'h77; we_i = 1'b1; tx_ready_i = 1'b1;
    void'(txq.pop_front());
    txq.push_back(8'h77);
    @(negedge clk);
    we_i = 1'b0; tx_ready_i = 1'b0;
    cpu_write(2'd0, 32'h10);
    cpu_read(2'd0, d);
    total++;
    if (d !== 32'h304) begin bad++; $display("FAIL push_pop_count: got %h expected 00000304", d); end
    drain_tx("tx_overflow");
  endtask

  task automatic test_rx();
    logic [31:0] d;
    rx_push(8'h55);
    rx_push(8'hAA);
    cpu_read(2'd0, d);
    total++;
    if (d[19:16] !== 4'd2) begin bad++; $display("FAIL rx_count: got %0d expected 2", d[19:16]); end
    for (int i = 0; i < 2; i++) begin
      cpu_read(2'd2, d);
      total++;
      if (d !== {24'd0, rxq[0]}) begin bad++; $display("FAIL rx_read%0d: got %h expected %h", i, d, rxq[0]); end
      void'(rxq.pop_front());
    end
    cpu_read(2'd2, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL rx_empty_read: got %h expected 0", d); end
    cpu_read(2'd0, d);
    total++;
    if (d !== 32'h5) begin bad++; $display("FAIL rx_empty_status: got %h expected 00000005", d); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) rx_push(8'(8'hC0 + i));
    cpu_read(2'd0, d);
    total++;
    if (d !== 32'h40029) begin bad++; $display("FAIL rx_ovr_status: got %h expected 00040029", d); end
    @(negedge clk);
    addr_i = 2'd0; wdata_i = 32'h20; we_i = 1'b1; rx_data_i = 8'hEE; rx_valid_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0; rx_valid_i = 1'b0;
    cpu_read(2'd0, d);
    total++;
    if (d[5] !== 1'b1) begin bad++; $display("FAIL rx_ovr_setwins: got %0b expected 1", d[5]); end
    cpu_write(2'd0, 32'h20);
    cpu_read(2'd0, d);
    total++;
    if (d[5] !== 1'b0) begin bad++; $display("FAIL rx_ovr_clear: got %0b expected 0", d[5]); end
    while (rxq.size() > 0) begin
      cpu_read(2'd2, d);
      total++;
      if (d !== {24'd0, rxq[0]}) begin bad++; $display("FAIL rx_drain: got %h expected %h", d, rxq[0]); end
      void'(rxq.pop_front());
    end
  endtask

  task automatic test_we_re_same();
    logic [31:0] d;
    logic [31:0] held;
    cpu_read(2'd0, held);
    @(negedge clk);
    addr_i = 2'd3; wdata_i = 32'hFFFF_FFF2; we_i = 1'b1; re_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0; re_i = 1'b0;
    total++;
    if (rdata_o !== held) begin bad++; $display("FAIL we_re_hold: got %h expected %h", rdata_o, held); end
    cpu_read(2'd3, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL irqen_read: got %h expected 00000002", d); end
  endtask

`ifdef UART_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    cpu_write(2'd3, 32'h2);
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_idle: got %0b expected 0", irq_o); end
    rx_push(8'h5A);
    @(negedge clk);
    total++;
    if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_set: got %0b expected 1", irq_o); end
    @(negedge clk);
    addr_i = 2'd2; re_i = 1'b1;
    @(negedge clk);
    re_i = 1'b0;
    void'(rxq.pop_front());
    total++;
    if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_lag: got %0b expected 1", irq_o); end
    @(negedge clk);
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_clear: got %0b expected 0", irq_o); end
    cpu_write(2'd3, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_tx_stream();
    test_tx_overflow();
    test_rx();
    test_rx_overrun();
    test_we_re_same();
`ifdef UART_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
